// File: rtl/fetch_ctrl_if.sv
// Fetch-controller bus bundle: i-cache read port, redirect input and decode-side queue head.
// The master modport is the fetch controller; the slave modport is the cache/decode environment.
interface fetch_ctrl_if;
  logic        ic_en;
  logic [31:0] ic_addr;
  logic [31:0] ic_rdata;
  logic        ic_rvalid;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;

  modport master (
    output ic_en, ic_addr, out_valid, out_pc, out_instr,
    input  ic_rdata, ic_rvalid, redirect_valid, redirect_pc, out_ready
  );

  modport slave (
    input  ic_en, ic_addr, out_valid, out_pc, out_instr,
    output ic_rdata, ic_rvalid, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: sequential PC generation, 1-cycle i-cache tagging, fetch queue, redirects.
// Optional macro FETCH_CTRL_PERF_EN adds perf_fetched / perf_squashed counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          FQ_DEPTH = 4
) (
  input logic          clk,
  input logic          rst,
  fetch_ctrl_if.master bus
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0]  perf_fetched,
  output logic [31:0]  perf_squashed
`endif
);
  localparam int          AW  = $clog2(FQ_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {BOOT = 2'd0, RUN = 2'd1, FLUSH = 2'd2} state_t;

  state_t        state_r, state_next_s;
  logic [31:0]   pc_r, pend_pc_r;
  logic          pend_valid_r, squash_r;
  logic [CW-1:0] count_r, credit_s;
  logic [AW-1:0] rd_ptr_r, wr_ptr_r;
  logic [31:0]   q_pc_r    [FQ_DEPTH];
  logic [31:0]   q_instr_r [FQ_DEPTH];
  logic          issue_s, push_s, pop_s, squash_s, out_valid_s;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= BOOT;
    else     state_r <= state_next_s;
  end

  // FSM next state: any redirect (re)enters FLUSH for one bubble
  always_comb begin
    state_next_s = state_r;
    if (bus.redirect_valid) begin
      state_next_s = FLUSH;
    end else begin
      case (state_r)
        BOOT:    state_next_s = RUN;
        RUN:     state_next_s = RUN;
        FLUSH:   state_next_s = RUN;
        default: state_next_s = BOOT;
      endcase
    end
  end

  // FSM outputs: issue only with a free slot for the in-flight word; a same-cycle pop earns no credit
  always_comb begin
    credit_s = count_r + CW'(pend_valid_r);
    issue_s  = 1'b0;
    if (state_r == RUN && !bus.redirect_valid) issue_s = (credit_s < CW'(FQ_DEPTH));
    else                                       issue_s = 1'b0;
  end

  // a redirect kills the response returning in its own cycle and the one after it
  assign squash_s    = bus.redirect_valid || squash_r;
  assign push_s      = pend_valid_r && bus.ic_rvalid && !squash_s;
  assign out_valid_s = (count_r != {CW{1'b0}});
  assign pop_s       = out_valid_s && bus.out_ready;

  assign bus.ic_en     = issue_s;
  assign bus.ic_addr   = pc_r;
  assign bus.out_valid = out_valid_s;
  assign bus.out_pc    = out_valid_s ? q_pc_r[rd_ptr_r]    : 32'h0000_0000;
  assign bus.out_instr = out_valid_s ? q_instr_r[rd_ptr_r] : NOP;

  // PC sequencing and in-flight request tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r         <= RESET_PC;
      pend_pc_r    <= RESET_PC;
      pend_valid_r <= 1'b0;
      squash_r     <= 1'b0;
    end else begin
      squash_r     <= bus.redirect_valid;
      pend_valid_r <= issue_s;
      if (issue_s) pend_pc_r <= pc_r;
      if (bus.redirect_valid) pc_r <= bus.redirect_pc & 32'hFFFF_FFFC;
      else if (issue_s)       pc_r <= pc_r + 32'h0000_0004;
    end
  end

  // queue occupancy and pointers; a redirect empties the queue after honouring a same-cycle pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
    end else if (bus.redirect_valid) begin
      count_r  <= {CW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
    end else begin
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
    end
  end

  // queue storage, written on push only
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_pc_r[wr_ptr_r]    <= pend_pc_r;
      q_instr_r[wr_ptr_r] <= bus.ic_rdata;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] flushed_s;
  assign flushed_s = bus.redirect_valid ? 32'(count_r - CW'(pop_s)) : 32'h0000_0000;

  // performance counters, free-running with wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetched  <= 32'h0000_0000;
      perf_squashed <= 32'h0000_0000;
    end else begin
      perf_fetched  <= perf_fetched + 32'(push_s);
      perf_squashed <= perf_squashed + flushed_s
                       + 32'(pend_valid_r && bus.ic_rvalid && squash_s);
    end
  end
`endif

  // every issued read must be answered in the following cycle
  a_rvalid_follows: assert property (@(posedge clk) disable iff (rst) pend_valid_r |-> bus.ic_rvalid);

endmodule
